// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Hazard detection and operand-forwarding control for a 5-stage MIPS pipeline.
//   Keeps the destination tags of the instructions in EX and MEM, registers
//   the ALU operand selects for the instruction moving from ID into EX, raises
//   the load-use and multi-cycle MDU stalls, and counts stall cycles.
//
//   Ports
//     clk, rst_n            rising-edge clock, asynchronous active-low reset
//     freeze_i              external freeze: every register holds
//     flush_i               ID instruction killed, bubble enters EX
//     id_valid .. id_is_mdu decoded fields of the instruction in ID
//     stall_id              hold PC and IF/ID, bubble into EX (combinational)
//     fwd_a, fwd_b          EX operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
//     mdu_busy              multi-cycle MDU operation in flight
//     stall_cnt             saturating count of unfrozen stall cycles
//
//   The WB-stage producer needs no tag here: the register file writes before
//   it is read in ID, so a value leaving WB is already visible as "00".
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze_i,
  input  logic              flush_i,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_is_mdu,
  output logic              stall_id,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int              MCW      = $clog2(MDU_LATENCY + 1);
  localparam logic [MCW-1:0]  MDU_LOAD = MCW'(MDU_LATENCY);

  // Producer tag match; register 0 is never a real dependency.
  function automatic logic tag_match(input logic              vld,
                                     input logic              rw,
                                     input logic [REG_AW-1:0] dest,
                                     input logic [REG_AW-1:0] src,
                                     input logic              use_src);
    return vld & rw & (dest == src) & (src != '0) & use_src;
  endfunction

  // The youngest producer (EX) wins over the older one (MEM).
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)       return 2'b10;
    else if (hit_mem) return 2'b01;
    else              return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage tags
  logic              ex_vld, ex_rw, ex_ld;
  logic [REG_AW-1:0] ex_dest;
  logic              mem_vld, mem_rw;
  logic [REG_AW-1:0] mem_dest;

  // MDU tracking
  logic [MCW-1:0]    mdu_cnt;
  logic [REG_AW-1:0] mdu_dest;

  logic hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
  logic load_use, mdu_raw, mdu_waw, mdu_hazard;
  logic bubble, mdu_issue;

  // ID-stage hazard evaluation
  always_comb begin
    hit_ex_rs  = tag_match(ex_vld,  ex_rw,  ex_dest,  id_rs, id_use_rs);
    hit_ex_rt  = tag_match(ex_vld,  ex_rw,  ex_dest,  id_rt, id_use_rt);
    hit_mem_rs = tag_match(mem_vld, mem_rw, mem_dest, id_rs, id_use_rs);
    hit_mem_rt = tag_match(mem_vld, mem_rw, mem_dest, id_rt, id_use_rt);

    load_use   = ex_ld & (hit_ex_rs | hit_ex_rt);

    // The in-flight MDU result is modelled as a producer with permanent
    // valid/write while the countdown runs.
    mdu_raw    = tag_match(mdu_busy, 1'b1, mdu_dest, id_rs, id_use_rs) |
                 tag_match(mdu_busy, 1'b1, mdu_dest, id_rt, id_use_rt);
    mdu_waw    = tag_match(mdu_busy, 1'b1, mdu_dest, id_dest, id_reg_write);
    mdu_hazard = mdu_raw | mdu_waw | (mdu_busy & id_is_mdu);

    stall_id   = id_valid & ~flush_i & (load_use | mdu_hazard);
    bubble     = stall_id | flush_i | ~id_valid;
    mdu_issue  = ~bubble & id_is_mdu;
  end

  assign mdu_busy = (mdu_cnt != '0);

  // ID -> EX -> MEM control/tag boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld    <= 1'b0;
      ex_rw     <= 1'b0;
      ex_ld     <= 1'b0;
      mem_vld   <= 1'b0;
      mem_rw    <= 1'b0;
      mdu_cnt   <= '0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      stall_cnt <= '0;
    end else if (!freeze_i) begin
      mem_vld <= ex_vld;
      mem_rw  <= ex_rw;
      if (bubble) begin
        ex_vld <= 1'b0;
        ex_rw  <= 1'b0;
        ex_ld  <= 1'b0;
        fwd_a  <= 2'b00;
        fwd_b  <= 2'b00;
      end else begin
        ex_vld <= 1'b1;
        ex_rw  <= id_reg_write;
        ex_ld  <= id_is_load;
        fwd_a  <= fwd_sel(hit_ex_rs, hit_mem_rs);
        fwd_b  <= fwd_sel(hit_ex_rt, hit_mem_rt);
      end
      // Issue cannot collide with a running countdown: a busy MDU stalls it.
      if (mdu_issue)     mdu_cnt <= MDU_LOAD;
      else if (mdu_busy) mdu_cnt <= mdu_cnt - 1'b1;
      if (stall_id)      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // ID -> EX -> MEM destination fields (qualified by the valid tags above)
  always_ff @(posedge clk) begin
    if (!freeze_i) begin
      mem_dest <= ex_dest;
      if (!bubble)   ex_dest  <= id_dest;
      if (mdu_issue) mdu_dest <= id_dest;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

  localparam int CW = 3;   // small counter so saturation is reachable

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          freeze_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          id_valid = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, id_dest = '0;
  logic          id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic          id_reg_write = 1'b0, id_is_load = 1'b0, id_is_mdu = 1'b0;
  logic          stall_id;
  logic [1:0]    fwd_a, fwd_b;
  logic          mdu_busy;
  logic [CW-1:0] stall_cnt;

  hazard_fwd_ctrl #(.REG_AW(5), .MDU_LATENCY(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .freeze_i(freeze_i), .flush_i(flush_i),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
    .stall_id(stall_id), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [4:0] rs, rt; logic urs, urt; logic [4:0] dst; logic rw, ld, mdu;
  } ins_t;

  typedef struct {
    string nm; logic stall; logic [1:0] fa, fb; logic busy; int cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  int   popped = 0;
  logic chk_pulse = 1'b0;

  function automatic ins_t nop();
    return '0;
  endfunction
  function automatic ins_t alu(int rd, int rs, int rt);
    return '{1'b1, 5'(rs), 5'(rt), 1'b1, 1'b1, 5'(rd), 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic ins_t lw(int rt, int base);
    return '{1'b1, 5'(base), 5'(rt), 1'b1, 1'b0, 5'(rt), 1'b1, 1'b1, 1'b0};
  endfunction
  function automatic ins_t mdu(int rd, int rs, int rt);
    return '{1'b1, 5'(rs), 5'(rt), 1'b1, 1'b1, 5'(rd), 1'b1, 1'b0, 1'b1};
  endfunction

  task automatic drive(input ins_t i, input logic fl, input logic fz);
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_use_rs = i.urs; id_use_rt = i.urt;
    id_dest = i.dst; id_reg_write = i.rw; id_is_load = i.ld; id_is_mdu = i.mdu;
    flush_i = fl; freeze_i = fz;
  endtask

  task automatic expect_now(input string nm, input logic es, input logic [1:0] efa,
                            input logic [1:0] efb, input logic eb, input int ec);
    exp_t e;
    e.nm = nm; e.stall = es; e.fa = efa; e.fb = efb; e.busy = eb; e.cnt = ec;
    sb.push_back(e);
    pushed++;
  endtask

  // One cycle: apply ID inputs just after the rising edge and queue what the
  // DUT must show before the next edge (stall for these inputs, registered
  // outputs as left by the previous edge).
  task automatic c(input string nm, input ins_t i, input logic fl, input logic fz,
                   input logic es, input logic [1:0] efa, input logic [1:0] efb,
                   input logic eb, input int ec);
    @(posedge clk); #1;
    drive(i, fl, fz);
    expect_now(nm, es, efa, efb, eb, ec);
  endtask

  task automatic chk(input string nm, input string f, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, exp);
    end
  endtask

  // Monitor: compares on every falling edge, or on demand for asynchronous events.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge chk_pulse);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        popped++;
        chk(e.nm, "stall_id",  int'(stall_id),  int'(e.stall));
        chk(e.nm, "fwd_a",     int'(fwd_a),     int'(e.fa));
        chk(e.nm, "fwd_b",     int'(fwd_b),     int'(e.fb));
        chk(e.nm, "mdu_busy",  int'(mdu_busy),  int'(e.busy));
        chk(e.nm, "stall_cnt", int'(stall_cnt), e.cnt);
      end
    end
  end

  initial begin
    // Reset state
    c("reset",      nop(),           0, 0, 0, 2'b00, 2'b00, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    // EX/MEM forwarding into rs: add $3,$1,$2 ; sub $4,$3,$5
    c("add3",       alu(3, 1, 2),    0, 0, 0, 2'b00, 2'b00, 0, 0);
    c("sub4",       alu(4, 3, 5),    0, 0, 0, 2'b00, 2'b00, 0, 0);
    c("sub_in_ex",  nop(),           0, 0, 0, 2'b10, 2'b00, 0, 0);
    // MEM/WB forwarding into rt: add $3 ; nop ; or $6,$7,$3
    c("add3b",      alu(3, 1, 2),    0, 0, 0, 2'b00, 2'b00, 0, 0);
    c("nop_gap",    nop(),           0, 0, 0, 2'b00, 2'b00, 0, 0);
    c("or6",        alu(6, 7, 3),    0, 0, 0, 2'b00, 2'b00, 0, 0);
    c("or_in_ex",   alu(3, 1, 2),    0, 0, 0, 2'b00, 2'b01, 0, 0);
    // Youngest producer wins: add $3 ; sub $3 ; and $7,$3,$3
    c("sub3",       alu(3, 4, 5),    0, 0, 0, 2'b00, 2'b00, 0, 0);
    c("and7",       alu(7, 3, 3),    0, 0, 0, 2'b00, 2'b00, 0, 0);
    c("and_in_ex",  nop(),           0, 0, 0, 2'b10, 2'b10, 0, 0);
    // Load-use: lw $8,0($1) ; add $9,$8,$8
    c("lw8",        lw(8, 1),        0, 0, 0, 2'b00, 2'b00, 0, 0);
    c("lu_stall",   alu(9, 8, 8),    0, 0, 1, 2'b00, 2'b00, 0, 0);
    c("lu_release", alu(9, 8, 8),    0, 0, 0, 2'b00, 2'b00, 0, 1);
    c("lu_in_ex",   nop(),           0, 0, 0, 2'b01, 2'b01, 0, 1);
    // MDU RAW: mult $10 ; add $11,$10,$0
    c("mult10",     mdu(10, 1, 2),   0, 0, 0, 2'b00, 2'b00, 0, 1);
    c("mdu_raw1",   alu(11, 10, 0),  0, 0, 1, 2'b00, 2'b00, 1, 1);
    c("mdu_raw2",   alu(11, 10, 0),  0, 0, 1, 2'b00, 2'b00, 1, 2);
    c("mdu_raw3",   alu(11, 10, 0),  0, 0, 1, 2'b00, 2'b00, 1, 3);
    c("mdu_raw4",   alu(11, 10, 0),  0, 0, 1, 2'b00, 2'b00, 1, 4);
    c("mdu_done",   alu(11, 10, 0),  0, 0, 0, 2'b00, 2'b00, 0, 5);
    c("mdu_cons",   nop(),           0, 0, 0, 2'b00, 2'b00, 0, 5);
    // Register $0: lw $0 ; add $5,$0,$0 -> no stall, no forward
    c("lw0",        lw(0, 1),        0, 0, 0, 2'b00, 2'b00, 0, 5);
    c("use0",       alu(5, 0, 0),    0, 0, 0, 2'b00, 2'b00, 0, 5);
    c("use0_in_ex", nop(),           0, 0, 0, 2'b00, 2'b00, 0, 5);
    // Flush during load-use
    c("lw8b",       lw(8, 1),        0, 0, 0, 2'b00, 2'b00, 0, 5);
    c("flush_lu",   alu(9, 8, 8),    1, 0, 0, 2'b00, 2'b00, 0, 5);
    c("post_flush", alu(9, 8, 8),    0, 0, 0, 2'b00, 2'b00, 0, 5);
    c("pf_in_ex",   nop(),           0, 0, 0, 2'b01, 2'b01, 0, 5);
    // Structural MDU stall; counter saturates at 7
    c("mult12",     mdu(12, 1, 2),   0, 0, 0, 2'b00, 2'b00, 0, 5);
    c("mdu_str1",   mdu(13, 1, 2),   0, 0, 1, 2'b00, 2'b00, 1, 5);
    c("mdu_str2",   mdu(13, 1, 2),   0, 0, 1, 2'b00, 2'b00, 1, 6);
    c("mdu_str3",   mdu(13, 1, 2),   0, 0, 1, 2'b00, 2'b00, 1, 7);
    c("cnt_sat",    mdu(13, 1, 2),   0, 0, 1, 2'b00, 2'b00, 1, 7);
    c("mult13",     mdu(13, 1, 2),   0, 0, 0, 2'b00, 2'b00, 0, 7);
    c("add14",      alu(14, 1, 2),   0, 0, 0, 2'b00, 2'b00, 1, 7);
    c("add15",      alu(15, 14, 0),  0, 0, 0, 2'b00, 2'b00, 1, 7);
    c("pre_reset",  nop(),           0, 0, 0, 2'b10, 2'b00, 1, 7);
    // Asynchronous reset mid-MDU (countdown at 2), checked before any edge
    @(negedge clk); #2;
    rst_n = 1'b0;
    expect_now("async_rst", 0, 2'b00, 2'b00, 0, 0);
    #1 chk_pulse = 1'b1;
    #1 chk_pulse = 1'b0;
    c("in_reset",   nop(),           0, 0, 0, 2'b00, 2'b00, 0, 0);
    // Freeze during a load-use stall holds everything
    @(posedge clk); #1 rst_n = 1'b1;
    c("add3c",      alu(3, 1, 2),    0, 0, 0, 2'b00, 2'b00, 0, 0);
    c("lw8c",       lw(8, 3),        0, 0, 0, 2'b00, 2'b00, 0, 0);
    c("frz1",       alu(9, 8, 1),    0, 1, 1, 2'b10, 2'b00, 0, 0);
    c("frz2",       alu(9, 8, 1),    0, 1, 1, 2'b10, 2'b00, 0, 0);
    c("frz3",       alu(9, 8, 1),    0, 1, 1, 2'b10, 2'b00, 0, 0);
    c("unfrz",      alu(9, 8, 1),    0, 0, 1, 2'b10, 2'b00, 0, 0);
    c("frz_rel",    alu(9, 8, 1),    0, 0, 0, 2'b00, 2'b00, 0, 1);
    c("frz_in_ex",  nop(),           0, 0, 0, 2'b01, 2'b00, 0, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard", "drained", popped, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
